// File: rtl/ps2_key_event_decoder.sv
// Set-2 scan-code stream to key-event decoder with typematic suppression
// and a first-word-fall-through event FIFO toward the note mapper.
module ps2_key_event_decoder #(
    parameter int DEPTH           = 4,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [7:0]             scan_code_i,
    input  logic                   scan_valid_i,
    output logic [7:0]             evt_code_o,
    output logic                   evt_ext_o,
    output logic                   evt_break_o,
    output logic                   evt_valid_o,
    input  logic                   evt_ready_i,
    output logic [$clog2(DEPTH):0] fifo_count_o,
    output logic                   overflow_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP} stateT;

    stateT        state_q, state_d;
    logic [2:0]   skipCnt_q, skipCnt_d;
    logic [255:0] held_q, held_d;
    logic [9:0]   mem_q [DEPTH];
    logic [AW-1:0] rdPtr_q, wrPtr_q, rdNext;
    logic [AW:0]  count_q, count_d;
    logic [9:0]   head_q, head_d;
    logic         overflow_q;

    logic       isCtrl, evtCand, evtGen, evtExt, evtBrk, tracked;
    logic       push, pop, full;
    logic [7:0] heldIdx;
    logic [9:0] pushEntry;

    always_comb begin
        state_d   = state_q;
        skipCnt_d = skipCnt_q;
        held_d    = held_q;
        evtCand   = 1'b0;
        evtGen    = 1'b0;
        evtExt    = 1'b0;
        evtBrk    = 1'b0;
        isCtrl    = scan_code_i inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
        tracked   = ~scan_code_i[7];

        if (scan_valid_i) begin
            if (state_q == SKIP) begin
                skipCnt_d = skipCnt_q - 3'd1;
                if (skipCnt_q == 3'd1) state_d = IDLE;
            end else if (scan_code_i == 8'hE1) begin
                state_d   = SKIP;
                skipCnt_d = 3'd7;
            end else if (scan_code_i == 8'hE0) begin
                state_d = GOT_E0;
            end else if (scan_code_i == 8'hF0) begin
                state_d = (state_q == GOT_E0) ? GOT_E0F0 : GOT_F0;
            end else if (isCtrl) begin
                state_d = IDLE;
            end else begin
                state_d = IDLE;
                evtCand = 1'b1;
                evtExt  = (state_q == GOT_E0) || (state_q == GOT_E0F0);
                evtBrk  = (state_q == GOT_F0) || (state_q == GOT_E0F0);
            end
        end

        heldIdx = {evtExt, scan_code_i[6:0]};
        // Held bits move with the generated event, independent of FIFO space.
        if (evtCand) begin
            if (evtBrk) begin
                evtGen = 1'b1;
                if (tracked) held_d[heldIdx] = 1'b0;
            end else if (!(SUPPRESS_REPEAT && tracked && held_q[heldIdx])) begin
                evtGen = 1'b1;
                if (tracked) held_d[heldIdx] = 1'b1;
            end
        end
    end

    always_comb begin
        pushEntry = {evtExt, evtBrk, scan_code_i};
        full      = (count_q == (AW+1)'(DEPTH));
        pop       = (count_q != '0) && evt_ready_i;
        push      = evtGen && (!full || pop);
        rdNext    = rdPtr_q + AW'(1);
        count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
        head_d    = head_q;
        // The head register tracks whatever entry sits at the read pointer next cycle.
        if (push && ((count_q == '0) || ((count_q == (AW+1)'(1)) && pop)))
            head_d = pushEntry;
        else if (pop && (count_q > (AW+1)'(1)))
            head_d = mem_q[rdNext];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            skipCnt_q  <= 3'd0;
            held_q     <= '0;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            head_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            skipCnt_q <= skipCnt_d;
            held_q    <= held_d;
            count_q   <= count_d;
            head_q    <= head_d;
            if (push) wrPtr_q <= wrPtr_q + AW'(1);
            if (pop)  rdPtr_q <= rdNext;
            if (evtGen && !push) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wrPtr_q] <= pushEntry;
    end

    assign evt_ext_o    = head_q[9];
    assign evt_break_o  = head_q[8];
    assign evt_code_o   = head_q[7:0];
    assign evt_valid_o  = (count_q != '0);
    assign fifo_count_o = count_q;
    assign overflow_o   = overflow_q;

endmodule

// File: doc/ps2_key_event_decoder.md
# ps2_key_event_decoder

Consumes the raw scan-code byte stream produced by the PS/2 receive stage and turns it into discrete key events: a code, an extended flag, and a make/break flag. It handles Set-2 prefixes (E0, F0, E0 F0), discards the Pause (E1) sequence and keyboard-controller replies, and suppresses typematic auto-repeat of keys already held. Events are buffered in a small first-word-fall-through FIFO with a valid/ready handshake toward the note-mapping logic downstream.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- SUPPRESS_REPEAT, 1, 1 = drop make events for keys already held; 0 = pass every make
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- scan_code  in  8  received scan-code byte, sampled when scan_valid=1
- scan_valid  in  1  one-cycle strobe per received byte
- evt_code  out  8  head event scan code (without prefixes)
- evt_ext  out  1  head event was E0-prefixed
- evt_break  out  1  head event is a release (F0-prefixed)
- evt_valid  out  1  FIFO non-empty; head fields valid
- evt_ready  in  1  consumer accepts head when evt_valid & evt_ready
- fifo_count  out  $clog2(DEPTH)+1  entries currently stored
- overflow  out  1  sticky: an event was dropped because the FIFO was full

## Operation
- Prefix FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP. All transitions occur only on cycles with scan_valid=1.
- IDLE: E0 -> GOT_E0; F0 -> GOT_F0; E1 -> SKIP (skip counter loaded with 7); controller bytes 00, AA, EE, FA, FC, FE, FF -> ignored, stay IDLE; any other byte -> make event {ext=0, brk=0}, stay IDLE.
- GOT_E0: F0 -> GOT_E0F0; E0 -> stay GOT_E0; E1 -> SKIP; controller byte -> ignored, IDLE; other -> make event {ext=1}, IDLE.
- GOT_F0: E0 -> GOT_E0; F0 -> stay GOT_F0; E1 -> SKIP; controller byte -> IDLE; other -> break event {ext=0, brk=1}, IDLE.
- GOT_E0F0: E0 -> GOT_E0; F0 -> GOT_F0; E1 -> SKIP; controller byte -> IDLE; other -> break event {ext=1, brk=1}, IDLE.
- SKIP: each byte decrements the 3-bit counter with no interpretation; the byte that decrements it to 0 returns the FSM to IDLE. This consumes exactly the 7 bytes following E1.
- Held table: 256 bits indexed {ext, code[6:0]}. Applies only to codes < 0x80; codes >= 0x80 (e.g. 83 = F7) are never tracked or suppressed.
- Make event: if SUPPRESS_REPEAT=1 and the held bit is set, the event is discarded. Otherwise it is pushed and the bit is set.
- Break event: always pushed; the held bit is cleared.
- The held table updates when an event is generated, even if the FIFO push is dropped.
- FIFO entry is {ext, brk, code} (10 bits). Push when an event is generated and the FIFO is not full, or is full with a pop in the same cycle. Otherwise the event is dropped and overflow is set.
- Pop on evt_valid & evt_ready. A pop on an empty FIFO is ignored. Pointers wrap modulo DEPTH.
- Outputs are first-word fall-through: evt_code/ext/break reflect the head entry whenever evt_valid=1. They hold their last value when the FIFO is empty.

## Timing
- Reset values: FSM=IDLE, skip counter=0, held table all 0, FIFO empty, evt_valid=0, evt_code=0, evt_ext=0, evt_break=0, fifo_count=0, overflow=0. Reset mid-sequence discards any pending prefix and any buffered events.
- Latency: a final byte strobed in cycle N produces evt_valid=1 in cycle N+1 (empty FIFO). Prefix bytes produce no output.
- Simultaneous push and pop: fifo_count is unchanged. When the FIFO is full, the push succeeds.
- Simultaneous push and pop with count=1: the head advances to the new entry in cycle N+1 and evt_valid stays 1.
- Back-to-back scan_valid on consecutive cycles is supported; one byte is processed per cycle.
- overflow clears only on rst.

## Test plan
- Make/break: bytes 1C, F0, 1C -> events {1C,ext0,brk0} then {1C,ext0,brk1}. First event is valid one cycle after the 1C strobe.
- Extended: E0, 75, E0, F0, 75 -> {75,ext1,brk0}, {75,ext1,brk1}. E0 75 and plain 75 are held independently.
- Typematic repeat: 1C ×5, then F0 1C with SUPPRESS_REPEAT=1 -> exactly 2 events. Same input with SUPPRESS_REPEAT=0 -> 6 events.
- Pause and noise: E1 14 77 E1 F0 14 F0 77 AA FA, then 15 -> a single event {15,0,0}. FSM is in IDLE afterward.
- FIFO boundary: DEPTH=4 with evt_ready=0; push 5 distinct makes (15, 1D, 24, 2D, 2C) -> fifo_count=4, overflow=1, 2C lost. Then evt_ready=1 drains 15, 1D, 24, 2D in order. A full FIFO with a simultaneous push and pop keeps count=4 and overflow unchanged.
- Reset mid-operation: feed E0 F0, assert rst for 1 cycle, then send 1C -> event {1C,ext0,brk0}. The FIFO was emptied and the held table cleared.
